// File: rtl/dilithium_top.sv
// Stream-protocol shell of the Dilithium keygen accelerator: gathers a 256-bit seed,
// kicks the engine, then forwards each key section to the output stream in a fixed order.
module dilithium_top #(
    parameter int HIGH_PERF = 1,
    parameter int SEC_LEVEL = 2,
    parameter int W         = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic           valid_i,
    output logic           ready_i,
    input  logic [W-1:0]   data_i,
    output logic           valid_o,
    input  logic           ready_o,
    output logic [W-1:0]   data_o,
    output logic           eng_start,
    output logic [255:0]   eng_seed,
    output logic [2:0]     eng_sec,
    input  logic           eng_valid,
    input  logic [W-1:0]   eng_data,
    output logic           eng_ready
);

    localparam int SEED_WORDS = 256 / W;
    localparam int LW         = (SEED_WORDS > 1) ? $clog2(SEED_WORDS) : 1;

    localparam int S1_BITS = (SEC_LEVEL == 2) ? 3072  : (SEC_LEVEL == 3) ? 5120  : 5376;
    localparam int S2_BITS = (SEC_LEVEL == 2) ? 3072  : 6144;
    localparam int T1_BITS = (SEC_LEVEL == 2) ? 10240 : (SEC_LEVEL == 3) ? 15360 : 20480;
    localparam int T0_BITS = (SEC_LEVEL == 2) ? 13312 : (SEC_LEVEL == 3) ? 19968 : 26624;

    // T0 is the largest section at every level, so it sizes the word counter.
    localparam int CW = $clog2(T0_BITS / W + 1);

    localparam logic [CW-1:0] SHORT_LAST = CW'(256 / W - 1);
    localparam logic [CW-1:0] S1_LAST    = CW'(S1_BITS / W - 1);
    localparam logic [CW-1:0] S2_LAST    = CW'(S2_BITS / W - 1);
    localparam logic [CW-1:0] T1_LAST    = CW'(T1_BITS / W - 1);
    localparam logic [CW-1:0] T0_LAST    = CW'(T0_BITS / W - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_UNLOAD} state_t;
    typedef enum logic [2:0] {
        SEC_RHO = 3'd0, SEC_K = 3'd1, SEC_S1 = 3'd2, SEC_S2 = 3'd3,
        SEC_T1  = 3'd4, SEC_T0 = 3'd5, SEC_TR = 3'd6
    } sec_t;

    state_t         r_state;
    state_t         w_next_state;
    sec_t           r_sec;
    sec_t           w_next_sec;
    logic           r_pass;
    logic [CW-1:0]  r_wcnt;
    logic [LW-1:0]  r_ld_cnt;
    logic [255:0]   r_buf;
    logic [255:0]   r_seed;
    logic           r_eng_start;

    logic           w_start_ok;
    logic           w_in_fire;
    logic           w_out_fire;
    logic           w_seed_last;
    logic [CW-1:0]  w_sec_last_idx;
    logic           w_sec_last_word;
    logic           w_run_done;
    logic           w_set_pass;
    logic [255:0]   w_buf_next;

    assign w_start_ok      = start && (mode == 2'd0);
    assign w_in_fire       = valid_i && (r_state == ST_LOAD);
    assign w_out_fire      = eng_valid && ready_o && (r_state == ST_UNLOAD);
    assign w_seed_last     = (r_ld_cnt == LW'(SEED_WORDS - 1));
    assign w_sec_last_word = (r_wcnt == w_sec_last_idx);
    // Earlier words shift toward the MSB, so the first word ends up on top.
    assign w_buf_next      = (r_buf << W) | 256'(data_i);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_sec_last_idx = SHORT_LAST;
        case (r_sec)
            SEC_S1:  w_sec_last_idx = S1_LAST;
            SEC_S2:  w_sec_last_idx = S2_LAST;
            SEC_T1:  w_sec_last_idx = T1_LAST;
            SEC_T0:  w_sec_last_idx = T0_LAST;
            default: w_sec_last_idx = SHORT_LAST;
        endcase
    end

    // Section sequencing; r_pass tells the secret-key RHO from the public-key RHO.
    always_comb begin
        w_next_sec = r_sec;
        w_run_done = 1'b0;
        w_set_pass = 1'b0;
        if (HIGH_PERF != 0) begin
            if (r_sec == SEC_TR) w_run_done = 1'b1;
            else                 w_next_sec = sec_t'(r_sec + 3'd1);
        end else begin
            case (r_sec)
                SEC_RHO: w_next_sec = r_pass ? SEC_T1 : SEC_K;
                SEC_K:   w_next_sec = SEC_TR;
                SEC_TR:  w_next_sec = SEC_S1;
                SEC_S1:  w_next_sec = SEC_S2;
                SEC_S2:  w_next_sec = SEC_T0;
                SEC_T0: begin
                    w_next_sec = SEC_RHO;
                    w_set_pass = 1'b1;
                end
                default: w_run_done = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_start_ok) w_next_state = ST_LOAD;
            ST_LOAD:   if (w_in_fire && w_seed_last) w_next_state = ST_UNLOAD;
            ST_UNLOAD: if (w_out_fire && w_sec_last_word && w_run_done) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_i   = 1'b0;
        valid_o   = 1'b0;
        data_o    = '0;
        eng_ready = 1'b0;
        eng_sec   = 3'd0;
        case (r_state)
            ST_LOAD:   ready_i = 1'b1;
            ST_UNLOAD: begin
                valid_o   = eng_valid;
                data_o    = eng_data;
                eng_ready = ready_o;
                eng_sec   = r_sec;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec       <= SEC_RHO;
            r_pass      <= 1'b0;
            r_wcnt      <= '0;
            r_ld_cnt    <= '0;
            r_buf       <= '0;
            r_seed      <= '0;
            r_eng_start <= 1'b0;
        end else begin
            r_eng_start <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_start_ok) begin
                    r_ld_cnt <= '0;
                    r_wcnt   <= '0;
                    r_sec    <= SEC_RHO;
                    r_pass   <= 1'b0;
                end
                ST_LOAD: if (w_in_fire) begin
                    r_buf <= w_buf_next;
                    if (w_seed_last) begin
                        r_seed      <= w_buf_next;
                        r_eng_start <= 1'b1;
                        r_ld_cnt    <= '0;
                    end else begin
                        r_ld_cnt <= r_ld_cnt + LW'(1);
                    end
                end
                ST_UNLOAD: if (w_out_fire) begin
                    if (w_sec_last_word) begin
                        r_wcnt <= '0;
                        if (w_run_done) begin
                            r_sec  <= SEC_RHO;
                            r_pass <= 1'b0;
                        end else begin
                            r_sec <= w_next_sec;
                            if (w_set_pass) r_pass <= 1'b1;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_start = r_eng_start;
    assign eng_seed  = r_seed;

endmodule

// File: tb/tb_dilithium_top.sv
// Bench for dilithium_top: three configurations side by side, each with its own engine
// model, checked against a section-order/word-count model derived from the key layout.
module tb_dilithium_top;

    localparam int W = 64;
    localparam int SEED_WORDS = 256 / W;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [1:0]     mode;
    logic           valid_i;
    logic [W-1:0]   data_i;

    int             n_checks = 0;
    int             n_fail   = 0;
    int             run_id   = 0;
    logic [255:0]   exp_seed = '0;
    event           end_ev;
    event           rst_ev;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Emission order: high-perf walks the ids in order; low-resource sends sk then pk.
    function automatic int sec_at(int hp, int p);
        if (hp != 0) return p;
        case (p)
            0: return 0;
            1: return 1;
            2: return 6;
            3: return 2;
            4: return 3;
            5: return 5;
            6: return 0;
            default: return 4;
        endcase
    endfunction

    function automatic int sec_words(int lvl, int s);
        int bits;
        case (s)
            2:       bits = (lvl == 2) ? 3072  : (lvl == 3) ? 5120  : 5376;
            3:       bits = (lvl == 2) ? 3072  : 6144;
            4:       bits = (lvl == 2) ? 10240 : (lvl == 3) ? 15360 : 20480;
            5:       bits = (lvl == 2) ? 13312 : (lvl == 3) ? 19968 : 26624;
            default: bits = 256;
        endcase
        return bits / W;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_cfg
        localparam int LVL   = (k == 2) ? 5 : 2;
        localparam int HP    = (k == 1) ? 0 : 1;
        localparam int NSEC  = (HP != 0) ? 7 : 8;
        localparam bit STALL = (k == 2);

        logic           ready_i, valid_o, ready_o, eng_start, eng_valid, eng_ready;
        logic [W-1:0]   data_o, eng_data;
        logic [255:0]   eng_seed;
        logic [2:0]     eng_sec;

        int pos, widx, total, acc, starts, extra, my_run;
        int e_idx, e_run;
        bit done, e_fire;

        dilithium_top #(.HIGH_PERF(HP), .SEC_LEVEL(LVL), .W(W)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .mode      (mode),
            .valid_i   (valid_i),
            .ready_i   (ready_i),
            .data_i    (data_i),
            .valid_o   (valid_o),
            .ready_o   (ready_o),
            .data_o    (data_o),
            .eng_start (eng_start),
            .eng_seed  (eng_seed),
            .eng_sec   (eng_sec),
            .eng_valid (eng_valid),
            .eng_data  (eng_data),
            .eng_ready (eng_ready)
        );

        function automatic logic [W-1:0] word_tag(int idx);
            return {8'(k), 8'(run_id), 48'(idx)};
        endfunction

        function automatic int exp_total();
            int sum = 0;
            for (int p = 0; p < NSEC; p++) sum += sec_words(LVL, sec_at(HP, p));
            return sum;
        endfunction

        // Engine: numbers each word it hands over; optionally stalls both sides.
        initial begin
            eng_valid = 1'b0;
            ready_o   = 1'b0;
            eng_data  = '0;
            e_idx     = 0;
            e_run     = -1;
            forever begin
                @(negedge clk);
                e_fire = eng_valid && eng_ready;
                @(posedge clk);
                #1;
                if (e_run != run_id) begin
                    e_run = run_id;
                    e_idx = 0;
                end else if (e_fire) begin
                    e_idx++;
                end
                if (STALL) begin
                    ready_o   = ~ready_o;
                    eng_valid = ($urandom_range(0, 3) == 0);
                end else begin
                    ready_o   = 1'b1;
                    eng_valid = 1'b1;
                end
                eng_data = eng_valid ? word_tag(e_idx) : {$urandom, $urandom};
            end
        end

        // Output monitor against the section-order model.
        initial begin
            my_run = -1;
            forever begin
                @(negedge clk);
                if (my_run != run_id) begin
                    my_run = run_id;
                    pos = 0; widx = 0; total = 0; acc = 0; starts = 0; extra = 0; done = 0;
                end
                if (!rst) begin
                    if (valid_i && ready_i) acc++;
                    if (eng_start) begin
                        starts++;
                        check($sformatf("c%0d_eng_seed", k), eng_seed, exp_seed);
                    end
                    if (valid_o && ready_o) begin
                        if (pos >= NSEC) begin
                            extra++;
                        end else begin
                            check($sformatf("c%0d_sec_p%0d", k, pos), 256'(eng_sec), 256'(sec_at(HP, pos)));
                            check($sformatf("c%0d_data_w%0d", k, total), 256'(data_o), 256'(word_tag(total)));
                            total++;
                            widx++;
                            if (widx == sec_words(LVL, sec_at(HP, pos))) begin
                                pos++;
                                widx = 0;
                            end
                        end
                    end
                    done = (pos == NSEC);
                end
            end
        end

        initial forever begin
            @(end_ev);
            check($sformatf("c%0d_total_words", k), 256'(total), 256'(exp_total()));
            check($sformatf("c%0d_seed_words", k), 256'(acc), 256'(SEED_WORDS));
            check($sformatf("c%0d_start_pulses", k), 256'(starts), 256'(1));
            check($sformatf("c%0d_extra_words", k), 256'(extra), 256'(0));
            check($sformatf("c%0d_seed_hold", k), eng_seed, exp_seed);
            check($sformatf("c%0d_idle_ready_i", k), 256'(ready_i), 256'(0));
            check($sformatf("c%0d_idle_valid_o", k), 256'(valid_o), 256'(0));
        end

        initial forever begin
            @(rst_ev);
            check($sformatf("c%0d_rst_ready_i", k), 256'(ready_i), 256'(0));
            check($sformatf("c%0d_rst_valid_o", k), 256'(valid_o), 256'(0));
            check($sformatf("c%0d_rst_data_o", k), 256'(data_o), 256'(0));
            check($sformatf("c%0d_rst_eng_ready", k), 256'(eng_ready), 256'(0));
            check($sformatf("c%0d_rst_eng_start", k), 256'(eng_start), 256'(0));
            check($sformatf("c%0d_rst_eng_sec", k), 256'(eng_sec), 256'(0));
            check($sformatf("c%0d_rst_eng_seed", k), eng_seed, 256'(0));
        end
    end

    task automatic pulse_start(input logic [1:0] m);
        @(posedge clk);
        #1;
        start = 1'b1;
        mode  = m;
        if (m == 2'd0) run_id++;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 2'd0;
    endtask

    task automatic load_seed(input logic [255:0] s);
        int n = 0;
        int guard = 0;
        exp_seed = s;
        while (n < SEED_WORDS && guard < 200) begin
            valid_i = ($urandom_range(0, 2) != 0);
            data_i  = valid_i ? s[255 - W * n -: W] : {$urandom, $urandom};
            @(negedge clk);
            if (valid_i && g_cfg[0].ready_i) n++;
            @(posedge clk);
            #1;
            guard++;
        end
        check("seed_load_words", 256'(n), 256'(SEED_WORDS));
        // Further offered words must be refused once the seed is complete.
        valid_i = 1'b1;
        repeat (3) begin
            data_i = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("run_complete", 256'(guard < 20000), 256'(1));
        repeat (10) @(negedge clk);
        -> end_ev;
        #1;
    endtask

    task automatic run_keygen(input logic [255:0] s);
        pulse_start(2'd0);
        load_seed(s);
        wait_done();
    endtask

    function automatic logic [255:0] rand_seed();
        logic [255:0] s;
        for (int i = 0; i < 8; i++) s[32 * i +: 32] = $urandom;
        return s;
    endfunction

    initial begin
        logic [255:0] seed_a;
        int guard;

        rst     = 1'b1;
        start   = 1'b0;
        mode    = 2'd0;
        valid_i = 1'b0;
        data_i  = '0;
        for (int i = 0; i < 32; i++) seed_a[255 - 8 * i -: 8] = 8'(i + 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        -> rst_ev;
        #1;
        @(negedge clk);
        rst = 1'b0;

        run_keygen(seed_a);

        // Reserved mode: start must be ignored, state from the last run untouched.
        pulse_start(2'($urandom_range(1, 3)));
        valid_i = 1'b1;
        data_i  = {$urandom, $urandom};
        repeat (5) @(negedge clk);
        valid_i = 1'b0;
        -> end_ev;
        #1;

        run_keygen(rand_seed());

        // Reset while configuration 0 is unloading T1.
        pulse_start(2'd0);
        load_seed(rand_seed());
        guard = 0;
        while (g_cfg[0].eng_sec != 3'd4 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("reach_t1", 256'(guard < 2000), 256'(1));
        #2;
        rst = 1'b1;
        #1;
        -> rst_ev;
        #1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_keygen(rand_seed());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
